smm_cif_mul_pipe: RTL and testbench
===================================

# smm_cif_mul_pipe

Parametrised pipelined multiplier/accumulator for the SMM_CIF datapath. It is the successor to the fixed two-cycle unsigned 32×32 multiplier and adds:
- configurable operand/result widths and pipeline depth;
- per-transaction signed/unsigned operand mode;
- a valid pipeline;
- an optional accumulate mode for convolution/FC dot products.

It sits between the operand fetch logic and the result write-back stage of the LeNet-5 compute array.

## Interface
Parameters:
- DIN0_WIDTH, 32, width of operand A
- DIN1_WIDTH, 32, width of operand B
- DOUT_WIDTH, 64, result/accumulator width; must be ≥ 2 and ≤ DIN0_WIDTH+DIN1_WIDTH+16
- NUM_STAGE, 2, pipeline latency in enabled cycles; legal range 1..6

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ce  in  1  clock enable; low freezes every register, including valid and accumulator
- in_valid  in  1  operands/mode valid this cycle
- din0  in  DIN0_WIDTH  operand A
- din1  in  DIN1_WIDTH  operand B
- din0_signed  in  1  1 = A is two's complement, 0 = unsigned
- din1_signed  in  1  1 = B is two's complement, 0 = unsigned
- acc_en  in  1  1 = add product into accumulator, 0 = plain multiply
- acc_clr  in  1  with acc_en: start a new sum (accumulator := product)
- out_valid  out  1  dout valid
- dout  out  DOUT_WIDTH  product or running sum
- acc_ovf  out  1  sticky: accumulation wrapped since last acc_clr

## Operation
- **Capture:** an input is accepted when in_valid=1 and ce=1. No backpressure exists; the consumer must take every out_valid.
- **Operand extension:** each operand is extended by one bit, sign-extended if its _signed bit is 1, else zero-extended.
- **Product:** the full (DIN0_WIDTH+DIN1_WIDTH+2)-bit signed product is sign-extended or truncated (LSBs kept) to DOUT_WIDTH.
- **Mode bits:** din0_signed, din1_signed, acc_en and acc_clr travel with the data through every stage.
- **Plain mode (acc_en=0):**
  - dout = product.
  - Accumulator and acc_ovf are unchanged.
- **Accumulate mode (acc_en=1):** applied at the final stage only.
  - acc_clr=1: acc := product and acc_ovf := 0.
  - acc_clr=0: acc := acc + product, modulo 2^DOUT_WIDTH, and dout = new acc.
  - Overflow: acc_ovf is set when signed addition overflows. A transaction is a signed accumulation if either operand's signed flag is 1. Otherwise overflow is an unsigned carry-out.
- **Bubbles:** cycles with in_valid=0 (and ce=1) create bubbles. A bubble reaching the final stage leaves the accumulator, dout and acc_ovf unchanged and drives out_valid=0.
- **Reset:** reset at any time, including mid-pipeline, discards all in-flight transactions.

## Timing
- **Latency:** exactly NUM_STAGE ce-high cycles from acceptance to out_valid=1.
- **Throughput:** one transaction per cycle.
- **Register placement:**
  - NUM_STAGE=1: the multiply-plus-accumulate is registered once.
  - NUM_STAGE≥2: stage 1 registers the extended operands and mode bits. The product is registered at stage NUM_STAGE-1 after NUM_STAGE-2 balancing stages. The accumulate/output register is stage NUM_STAGE.
- **ce stall:** ce=0 holds all outputs stable and does not count toward latency.
- **Back-to-back accumulates:** must chain correctly; the accumulator is forwarded in the final stage with no hazard bubble.
- **Reset values:** out_valid=0, dout=0, acc_ovf=0, accumulator=0, all pipeline valid bits 0.
- **Reset release:** the first input may be accepted on the first rising edge with reset low.

## Structure
- **Package smm_cif_mul_pkg:**
  - constant MUL_MAX_STAGE=6
  - function for extended-product width
  - typedef for the mode bundle {din0_signed, din1_signed, acc_en, acc_clr}
- **Sub-module smm_cif_pipe_reg:** parametrised width; async-reset register with ce and valid. Instantiated once per balancing stage.
- **Elaboration check:** the top-level asserts legal parameter ranges.

## Test plan
- **Unsigned plain, defaults:** din0=0xFFFFFFFF, din1=0xFFFFFFFF, unsigned → after 2 cycles out_valid=1, dout=0xFFFFFFFE00000001.
- **Signed × unsigned mix, DIN 8/8, DOUT 16:** din0=0x80 signed, din1=0xFF unsigned (-128×255) → dout=0x8080; with both signed (-128×-1) → dout=0x0080.
- **Accumulate, DIN 8/8, DOUT 16, NUM_STAGE=3:** back-to-back products 3×4 (acc_clr=1), then 5×6 and 7×8 → dout sequence 12, 42, 98 on consecutive cycles.
- **Overflow, DOUT 16 signed:** acc_clr 0x7F×0x7F (16129), then +0x7F×0x7F → dout=0x7E02 (32258), acc_ovf=0; one more add → dout wraps to 0xBD03, acc_ovf=1. Sticky until the next acc_clr.
- **ce stall / bubbles:** drop ce for 3 cycles mid-stream → outputs frozen, latency extended by 3. An in_valid gap → out_valid gap at the same position, with dout and acc unchanged.
- **Reset mid-operation:** assert reset with 2 transactions in flight → out_valid, dout and acc_ovf go 0 immediately. No stale output appears after release.

Source files
------------

// File: rtl/smm_cif_mul_pkg.sv
// Shared constants, types and helpers for the SMM_CIF pipelined multiplier/accumulator.
package smm_cif_mul_pkg;

    localparam int MUL_MAX_STAGE = 6;

    // Operands are widened by one bit each so signed and unsigned share one signed multiplier.
    function automatic int ext_prod_width(input int a_width, input int b_width);
        return a_width + b_width + 2;
    endfunction

    typedef struct packed {
        logic din0_signed;
        logic din1_signed;
        logic acc_en;
        logic acc_clr;
    } mul_mode_t;

    localparam int MODE_WIDTH = $bits(mul_mode_t);

endpackage

// File: rtl/smm_cif_pipe_reg.sv
// Clock-enabled pipeline register carrying a valid bit alongside its data word.
module smm_cif_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (ce) begin
            out_valid <= in_valid;
            dout      <= din;
        end
    end

endmodule

// File: rtl/smm_cif_mul_pipe.sv
// Pipelined signed/unsigned multiplier with optional accumulate at the final stage.
module smm_cif_mul_pipe
    import smm_cif_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = 32,
    parameter int DIN1_WIDTH = 32,
    parameter int DOUT_WIDTH = 64,
    parameter int NUM_STAGE  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  din0_signed,
    input  logic                  din1_signed,
    input  logic                  acc_en,
    input  logic                  acc_clr,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  acc_ovf
);

    localparam int PROD_WIDTH = ext_prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int LAST       = (NUM_STAGE >= 2) ? NUM_STAGE - 2 : 0;
    localparam int BAL_WIDTH  = MODE_WIDTH + DOUT_WIDTH;

    if (NUM_STAGE < 1 || NUM_STAGE > MUL_MAX_STAGE) begin : g_bad_stage
        $error("smm_cif_mul_pipe: NUM_STAGE %0d outside 1..%0d", NUM_STAGE, MUL_MAX_STAGE);
    end
    if (DOUT_WIDTH < 2 || DOUT_WIDTH > DIN0_WIDTH + DIN1_WIDTH + 16) begin : g_bad_dout
        $error("smm_cif_mul_pipe: DOUT_WIDTH %0d out of range", DOUT_WIDTH);
    end

    mul_mode_t                   mode_in;
    logic signed [DIN0_WIDTH:0]  op0_in;
    logic signed [DIN1_WIDTH:0]  op1_in;

    assign mode_in = mul_mode_t'({din0_signed, din1_signed, acc_en, acc_clr});
    assign op0_in  = {din0_signed & din0[DIN0_WIDTH-1], din0};
    assign op1_in  = {din1_signed & din1[DIN1_WIDTH-1], din1};

    logic                        op_valid;
    mul_mode_t                   op_mode;
    logic signed [DIN0_WIDTH:0]  op0;
    logic signed [DIN1_WIDTH:0]  op1;

    if (NUM_STAGE == 1) begin : g_comb_in
        assign op_valid = in_valid;
        assign op_mode  = mode_in;
        assign op0      = op0_in;
        assign op1      = op1_in;
    end else begin : g_reg_in
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                op_valid <= 1'b0;
                op_mode  <= '0;
                op0      <= '0;
                op1      <= '0;
            end else if (ce) begin
                op_valid <= in_valid;
                op_mode  <= mode_in;
                op0      <= op0_in;
                op1      <= op1_in;
            end
        end
    end

    logic signed [PROD_WIDTH-1:0] prod_full;
    logic        [DOUT_WIDTH-1:0] prod;

    assign prod_full = PROD_WIDTH'(op0) * PROD_WIDTH'(op1);
    assign prod      = DOUT_WIDTH'(prod_full);

    // Index 0 is the combinational product; each balancing stage adds one register.
    logic [BAL_WIDTH-1:0] bal_data  [0:LAST];
    logic                 bal_valid [0:LAST];

    assign bal_data[0]  = {op_mode, prod};
    assign bal_valid[0] = op_valid;

    for (genvar k = 0; k < NUM_STAGE - 2; k++) begin : g_bal
        smm_cif_pipe_reg #(
            .WIDTH(BAL_WIDTH)
        ) u_bal_reg (
            .clk      (clk),
            .reset    (reset),
            .ce       (ce),
            .in_valid (bal_valid[k]),
            .din      (bal_data[k]),
            .out_valid(bal_valid[k+1]),
            .dout     (bal_data[k+1])
        );
    end

    mul_mode_t             fin_mode;
    logic [DOUT_WIDTH-1:0] fin_prod;
    logic                  fin_valid;

    assign {fin_mode, fin_prod} = bal_data[LAST];
    assign fin_valid            = bal_valid[LAST];

    logic [DOUT_WIDTH-1:0] acc;
    logic [DOUT_WIDTH-1:0] sum;
    logic                  carry;
    logic                  sum_ovf;

    assign {carry, sum} = {1'b0, acc} + {1'b0, fin_prod};

    always_comb begin
        sum_ovf = carry;
        if (fin_mode.din0_signed | fin_mode.din1_signed) begin
            sum_ovf = (acc[DOUT_WIDTH-1] == fin_prod[DOUT_WIDTH-1]) &&
                      (sum[DOUT_WIDTH-1] != acc[DOUT_WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
        end else if (ce) begin
            out_valid <= fin_valid;
            if (fin_valid) begin
                if (!fin_mode.acc_en) begin
                    dout <= fin_prod;
                end else if (fin_mode.acc_clr) begin
                    acc     <= fin_prod;
                    dout    <= fin_prod;
                    acc_ovf <= 1'b0;
                end else begin
                    acc  <= sum;
                    dout <= sum;
                    if (sum_ovf) begin
                        acc_ovf <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_smm_cif_mul_pipe.sv
// Scoreboard bench: two configurations share stimulus; an arithmetic model predicts each output.
module tb_smm_cif_mul_pipe;

    localparam int S_A = 8,  S_B = 8,  S_D = 16, S_N = 3;
    localparam int L_A = 32, L_B = 32, L_D = 64, L_N = 2;

    typedef struct {
        logic [63:0] dout;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic        s0 = 1'b0, s1 = 1'b0, en = 1'b0, clr = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [31:0] a32 = '0, b32 = '0;

    logic        ov0, of0, ov1, of1;
    logic [15:0] d0;
    logic [63:0] d1;

    int errors = 0;
    int checks = 0;
    int ce_edges = 0;
    bit edge_en = 1'b0;

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [63:0] m_acc [2];
    bit          m_ovf [2];
    logic        last_v [2];
    logic [63:0] last_d [2];
    logic        last_o [2];

    always #5 clk = ~clk;

    smm_cif_mul_pipe #(
        .DIN0_WIDTH(S_A), .DIN1_WIDTH(S_B), .DOUT_WIDTH(S_D), .NUM_STAGE(S_N)
    ) u_small (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .din0(a8), .din1(b8), .din0_signed(s0), .din1_signed(s1),
        .acc_en(en), .acc_clr(clr),
        .out_valid(ov0), .dout(d0), .acc_ovf(of0)
    );

    smm_cif_mul_pipe #(
        .DIN0_WIDTH(L_A), .DIN1_WIDTH(L_B), .DOUT_WIDTH(L_D), .NUM_STAGE(L_N)
    ) u_large (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .din0(a32), .din1(b32), .din0_signed(s0), .din1_signed(s1),
        .acc_en(en), .acc_clr(clr),
        .out_valid(ov1), .dout(d1), .acc_ovf(of1)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mask(input int w);
        logic [127:0] m;
        m = (128'd1 << w) - 128'd1;
        return m[63:0];
    endfunction

    function automatic logic signed [127:0] to_signed(input logic [63:0] x, input int w);
        logic signed [127:0] v;
        v = {64'b0, x};
        if (x[w-1]) v = v - (128'sd1 <<< w);
        return v;
    endfunction

    // True mathematical product of the interpreted operands, reduced modulo 2^wd.
    function automatic logic [63:0] prod_model(input logic [31:0] a, input logic [31:0] b,
                                               input bit sa, input bit sb,
                                               input int wa, input int wb, input int wd);
        logic signed [127:0] ea, eb, p;
        ea = {96'b0, a};
        eb = {96'b0, b};
        if (sa && a[wa-1]) ea = ea - (128'sd1 <<< wa);
        if (sb && b[wb-1]) eb = eb - (128'sd1 <<< wb);
        p = ea * eb;
        return p[63:0] & mask(wd);
    endfunction

    task automatic accept(input int i, input logic [31:0] a, input logic [31:0] b);
        exp_t                e;
        int                  wa, wb, wd, ns;
        logic [63:0]         p, mk;
        logic signed [127:0] t, lim;
        logic [127:0]        u;
        wa = (i == 0) ? S_A : L_A;
        wb = (i == 0) ? S_B : L_B;
        wd = (i == 0) ? S_D : L_D;
        ns = (i == 0) ? S_N : L_N;
        mk = mask(wd);
        p  = prod_model(a, b, s0, s1, wa, wb, wd);
        if (!en) begin
            e.dout = p;
        end else if (clr) begin
            m_acc[i] = p;
            m_ovf[i] = 1'b0;
            e.dout   = p;
        end else begin
            if (s0 || s1) begin
                t   = to_signed(m_acc[i], wd) + to_signed(p, wd);
                lim = 128'sd1 <<< (wd - 1);
                if (t > lim - 128'sd1 || t < -lim) m_ovf[i] = 1'b1;
            end else begin
                u = {64'b0, m_acc[i]} + {64'b0, p};
                if (u > {64'b0, mk}) m_ovf[i] = 1'b1;
            end
            m_acc[i] = (m_acc[i] + p) & mk;
            e.dout   = m_acc[i];
        end
        e.ovf = m_ovf[i];
        e.due = ce_edges + ns - 1;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Acceptance side: sees the inputs exactly as the DUT does at each rising edge.
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = '0; m_ovf[i] = 1'b0;
            last_v[i] = 1'b0; last_d[i] = '0; last_o[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            if (reset) begin
                q0.delete();
                q1.delete();
                for (int i = 0; i < 2; i++) begin
                    m_acc[i] = '0;
                    m_ovf[i] = 1'b0;
                end
                edge_en = 1'b0;
            end else begin
                edge_en = ce;
                if (ce) begin
                    ce_edges++;
                    if (in_valid) begin
                        accept(0, {24'b0, a8}, {24'b0, b8});
                        accept(1, a32, b32);
                    end
                end
            end
        end
    end

    task automatic check_dut(input int i, input logic v, input logic [63:0] d, input logic o);
        exp_t  e;
        bit    due;
        string tag;
        tag = (i == 0) ? "small" : "large";
        if (reset) begin
            cmp({tag, "_rst_valid"}, {63'b0, v}, 64'd0);
            cmp({tag, "_rst_dout"}, d, 64'd0);
            cmp({tag, "_rst_ovf"}, {63'b0, o}, 64'd0);
            last_v[i] = 1'b0; last_d[i] = '0; last_o[i] = 1'b0;
            return;
        end
        if (!edge_en) begin
            cmp({tag, "_stall_valid"}, {63'b0, v}, {63'b0, last_v[i]});
            cmp({tag, "_stall_dout"}, d, last_d[i]);
            cmp({tag, "_stall_ovf"}, {63'b0, o}, {63'b0, last_o[i]});
            return;
        end
        if (i == 0) due = (q0.size() > 0) && (q0[0].due == ce_edges);
        else        due = (q1.size() > 0) && (q1[0].due == ce_edges);
        cmp({tag, "_valid"}, {63'b0, v}, {63'b0, due});
        if (due) begin
            if (i == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            cmp({tag, "_dout"}, d, e.dout);
            cmp({tag, "_ovf"}, {63'b0, o}, {63'b0, e.ovf});
            last_d[i] = e.dout;
            last_o[i] = e.ovf;
        end else begin
            cmp({tag, "_bubble_dout"}, d, last_d[i]);
            cmp({tag, "_bubble_ovf"}, {63'b0, o}, {63'b0, last_o[i]});
        end
        last_v[i] = due;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check_dut(0, ov0, {48'b0, d0}, of0);
            check_dut(1, ov1, d1, of1);
        end
    end

    task automatic drive(input logic v, input logic c, input logic [7:0] a, input logic [7:0] b,
                         input logic [31:0] wa, input logic [31:0] wb,
                         input logic sa, input logic sb, input logic e, input logic cl);
        in_valid = v; ce = c; a8 = a; b8 = b; a32 = wa; b32 = wb;
        s0 = sa; s1 = sb; en = e; clr = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random(input bit allow_stall);
        drive($urandom_range(0, 3) != 0,
              allow_stall ? ($urandom_range(0, 7) != 0) : 1'b1,
              8'($urandom), 8'($urandom), 32'($urandom), 32'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        drive(1, 1, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        drive(1, 1, 8'h80, 8'hFF, 32'h8000_0000, 32'hFF, 1, 0, 0, 0);
        drive(1, 1, 8'h80, 8'hFF, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 0, 0);
        drive(0, 1, 8'h00, 8'h00, 32'h0, 32'h0, 0, 0, 0, 0);
        drive(1, 1, 8'd3, 8'd4, 32'd3, 32'd4, 0, 0, 1, 1);
        drive(1, 1, 8'd5, 8'd6, 32'd5, 32'd6, 0, 0, 1, 0);
        drive(1, 1, 8'd7, 8'd8, 32'd7, 32'd8, 0, 0, 1, 0);
        repeat (3) drive(1, 0, 8'd9, 8'd9, 32'd9, 32'd9, 0, 0, 1, 0);
        drive(0, 1, 8'h00, 8'h00, 32'h0, 32'h0, 0, 0, 0, 0);
        drive(1, 1, 8'h7F, 8'h7F, 32'h7F, 32'h7F, 1, 1, 1, 1);
        drive(1, 1, 8'h7F, 8'h7F, 32'h7F, 32'h7F, 1, 1, 1, 0);
        drive(1, 1, 8'h7F, 8'h7F, 32'h7F, 32'h7F, 1, 1, 1, 0);
        drive(0, 1, 8'h00, 8'h00, 32'h0, 32'h0, 0, 0, 0, 0);
        drive(1, 1, 8'd2, 8'hFD, 32'd2, 32'hFFFF_FFFD, 1, 1, 0, 0);
        drive(1, 1, 8'h01, 8'h01, 32'h1, 32'h1, 1, 1, 1, 0);
        drive(1, 1, 8'h01, 8'h01, 32'h1, 32'h1, 0, 0, 1, 1);
        drive(1, 1, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 0);
        drive(1, 1, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 0);
        repeat (4) drive(0, 1, 8'h00, 8'h00, 32'h0, 32'h0, 0, 0, 0, 0);

        repeat (400) drive_random(1'b1);

        drive(1, 1, 8'd11, 8'd13, 32'd11, 32'd13, 0, 0, 1, 1);
        drive(1, 1, 8'd17, 8'd19, 32'd17, 32'd19, 0, 0, 1, 0);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        cmp("async_rst_valid_small", {63'b0, ov0}, 64'd0);
        cmp("async_rst_dout_small", {48'b0, d0}, 64'd0);
        cmp("async_rst_ovf_small", {63'b0, of0}, 64'd0);
        cmp("async_rst_valid_large", {63'b0, ov1}, 64'd0);
        cmp("async_rst_dout_large", d1, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        repeat (100) drive_random(1'b1);
        repeat (10) drive(0, 1, 8'h00, 8'h00, 32'h0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        cmp("drain_small_pending", 64'(q0.size()), 64'd0);
        cmp("drain_large_pending", 64'(q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
